// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants and types for the seven-segment display path.
//   SSD_BLANK / SSD_DASH : digit codes understood by the SSD decoder
//   SEG_OFF / AN_OFF     : all-dark segment and anode patterns (active-low)
//   digit_idx_t          : index of one of the four display digits
package ssd_pkg;

  localparam logic [3:0] SSD_BLANK = 4'd15;
  localparam logic [3:0] SSD_DASH  = 4'd10;
  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/ssd_scan_ctrl_ssd.sv
// SSD: combinational 4-bit code to seven-segment pattern decoder.
//   code [3:0] : digit code, 0-9 decimal, 10 dash, 11-14 b/C/d/E, 15 blank
//   seg  [7:0] : active-low pattern, [7:1] = segments a..g, [0] = decimal point
// The decimal point bit is always driven dark here; the scan controller
// overrides it per digit.
module SSD
  import ssd_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (code)
      4'd0:     seg = 8'b00000011;
      4'd1:     seg = 8'b10011111;
      4'd2:     seg = 8'b00100101;
      4'd3:     seg = 8'b00001101;
      4'd4:     seg = 8'b10011001;
      4'd5:     seg = 8'b01001001;
      4'd6:     seg = 8'b01000001;
      4'd7:     seg = 8'b00011111;
      4'd8:     seg = 8'b00000001;
      4'd9:     seg = 8'b00001001;
      SSD_DASH: seg = 8'b11111101;
      4'd11:    seg = 8'b11000001;
      4'd12:    seg = 8'b01100011;
      4'd13:    seg = 8'b10000101;
      4'd14:    seg = 8'b01100001;
      default:  seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: time-multiplexed scan controller for a 4-digit common-anode
// seven-segment display, sharing one SSD decoder across all digits.
//   clk, rst    : clock, asynchronous active-high reset
//   load        : one-cycle request to capture value/dp_mask
//   value[15:0] : four digit codes, [3:0] = digit 0 (rightmost)
//   dp_mask[3:0]: bit k lights the decimal point of digit k
//   blank_lz    : live enable for leading-zero blanking
//   seg[7:0]    : active-low segments, [7:1] = a..g, [0] = decimal point
//   an[3:0]     : active-low one-hot digit enables
//   frame_done  : one-cycle pulse after digit 3's slot ends
//   load_ack    : one-cycle pulse when a pending load reaches the display
// All outputs are registered and describe the previous cycle's scan state.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        load_ack
);

  localparam int              CW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW:0]     GUARD_CNT = (CW+1)'(GUARD);

  logic [CW-1:0] cnt;
  digit_idx_t    idx;
  logic          slot_end;
  logic          boundary;
  logic          commit;

  // Load handshake: load acts as a valid whose ready is permanently high, so
  // every asserted cycle is a transfer; the newest transfer always wins.
  logic          pend;
  logic [15:0]   pend_val;
  logic [3:0]    pend_dp;
  logic [15:0]   disp_val;
  logic [3:0]    disp_dp;

  logic [3:0]    dig0, dig1, dig2, dig3;
  logic          lz1, lz2, lz3;
  logic [3:0]    code_sel;
  logic          dp_on;
  logic [7:0]    dec_seg;
  logic          in_guard;
  logic [3:0]    an_next;

  assign slot_end = (cnt == CNT_LAST);
  assign boundary = slot_end && (idx == 2'd3);
  assign commit   = boundary && (pend || load);

  // Prescaler and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Pending and display registers. The display only changes at a frame
  // boundary so a digit word is never shown half-old, half-new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= 1'b0;
      pend_val <= '0;
      pend_dp  <= '0;
      disp_val <= 16'hFFFF;
      disp_dp  <= '0;
    end else if (boundary) begin
      if (load) begin
        disp_val <= value;
        disp_dp  <= dp_mask;
      end else if (pend) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end
      pend <= 1'b0;
    end else if (load) begin
      pend_val <= value;
      pend_dp  <= dp_mask;
      pend     <= 1'b1;
    end
  end

  assign dig0 = disp_val[3:0];
  assign dig1 = disp_val[7:4];
  assign dig2 = disp_val[11:8];
  assign dig3 = disp_val[15:12];

  // Blanking ripples down from the most significant digit; digit 0 always
  // shows so a zero value still displays "0".
  assign lz3 = blank_lz && (dig3 == 4'd0);
  assign lz2 = lz3 && (dig2 == 4'd0);
  assign lz1 = lz2 && (dig1 == 4'd0);

  always_comb begin
    code_sel = SSD_BLANK;
    case (idx)
      2'd0: code_sel = dig0;
      2'd1: code_sel = lz1 ? SSD_BLANK : dig1;
      2'd2: code_sel = lz2 ? SSD_BLANK : dig2;
      2'd3: code_sel = lz3 ? SSD_BLANK : dig3;
      default: code_sel = SSD_BLANK;
    endcase
  end

  assign dp_on = disp_dp[idx];

  SSD u_ssd (
    .code (code_sel),
    .seg  (dec_seg)
  );

  // Anodes stay dark for the first GUARD cycles of every slot so the previous
  // digit's segments cannot ghost onto the new digit.
  assign in_guard = ({1'b0, cnt} < GUARD_CNT);

  always_comb begin
    an_next = AN_OFF;
    if (!in_guard) begin
      an_next[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      frame_done <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      seg        <= {dec_seg[7:1], dec_seg[0] & ~dp_on};
      an         <= an_next;
      frame_done <= boundary;
      load_ack   <= commit;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: scoreboard bench for ssd_scan_ctrl with REFRESH_DIV=4,
// GUARD=1. The driver computes each cycle's expected outputs from a
// frame-position model (cycle number -> slot/phase) and queues them; a monitor
// pops one entry per clock and compares it against the registered outputs.
module tb_ssd_scan_ctrl;

  localparam int RD    = 4;
  localparam int GD    = 1;
  localparam int FRAME = 4 * RD;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic        blank_lz = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  logic        load_ack;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(
    .REFRESH_DIV (RD),
    .GUARD       (GD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done),
    .load_ack   (load_ack)
  );

  // scoreboard: {an, seg, frame_done, load_ack}
  logic [13:0] exp_q[$];
  logic [13:0] mon_exp;
  logic [13:0] mon_act;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          checking = 1'b0;

  // reference model state
  int          t;
  logic [15:0] m_show;
  logic [3:0]  m_dp;
  logic        m_pv;
  logic [15:0] m_pval;
  logic [3:0]  m_pdp;
  logic [6:0]  lit [16];   // lit segments a..g, active-high
  bit          blz_r = 1'b0;

  task automatic m_reset();
    t      = 0;
    m_show = 16'hFFFF;
    m_dp   = 4'h0;
    m_pv   = 1'b0;
    m_pval = '0;
    m_pdp  = '0;
  endtask

  function automatic logic [7:0] model_seg(input int slot, input logic blz);
    int          lead;
    bit          stop;
    logic [3:0]  code;
    logic [7:0]  s;
    lead = 0;
    stop = 1'b0;
    for (int i = 3; i >= 1; i--) begin
      if (!stop) begin
        if (m_show[4*i +: 4] == 4'd0) lead++;
        else stop = 1'b1;
      end
    end
    code = m_show[4*slot +: 4];
    if (blz && slot != 0 && slot >= 4 - lead) s = 8'hFF;
    else s = {~lit[code], 1'b1};
    if (m_dp[slot]) s[0] = 1'b0;
    return s;
  endfunction

  // driver tasks
  task automatic drive_cycle(input logic ld, input logic [15:0] v,
                             input logic [3:0] dm, input logic blz);
    int         phase;
    int         slot;
    bit         bnd;
    logic [3:0] e_an;
    load     = ld;
    value    = v;
    dp_mask  = dm;
    blank_lz = blz;
    phase = t % RD;
    slot  = (t / RD) % 4;
    bnd   = (phase == RD - 1) && (slot == 3);
    e_an  = 4'hF;
    if (phase >= GD) e_an[slot] = 1'b0;
    exp_q.push_back({e_an, model_seg(slot, blz), bnd, bnd && (m_pv || ld)});
    if (bnd) begin
      if (ld) begin
        m_show = v;
        m_dp   = dm;
      end else if (m_pv) begin
        m_show = m_pval;
        m_dp   = m_pdp;
      end
      m_pv = 1'b0;
    end else if (ld) begin
      m_pval = v;
      m_pdp  = dm;
      m_pv   = 1'b1;
    end
    t++;
  endtask

  task automatic step(input logic ld, input logic [15:0] v,
                      input logic [3:0] dm, input logic blz);
    @(negedge clk);
    drive_cycle(ld, v, dm, blz);
  endtask

  task automatic idle(input int n, input logic blz);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom), blz);
  endtask

  task automatic step_to_phase(input int target, input logic blz);
    for (int i = 0; i < FRAME && (t % FRAME) != target; i++) idle(1, blz);
  endtask

  task automatic check_reset(input string name);
    n_cmp++;
    if ({an, seg, frame_done, load_ack} !== {4'hF, 8'hFF, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL %s: an=%b seg=%b fd=%b ack=%b, required an=1111 seg=11111111 fd=0 ack=0",
               name, an, seg, frame_done, load_ack);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    checking = 1'b1;
    drive_cycle(1'b0, 16'h0000, 4'h0, 1'b0);
  endtask

  // monitor
  always @(posedge clk) begin
    #1;
    if (checking) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scan_out: output cycle with no expected entry");
      end else begin
        mon_exp = exp_q.pop_front();
        mon_act = {an, seg, frame_done, load_ack};
        if (mon_act !== mon_exp) begin
          n_bad++;
          $display("FAIL scan_out t=%0d: an=%b seg=%b fd=%b ack=%b, required an=%b seg=%b fd=%b ack=%b",
                   t, mon_act[13:10], mon_act[9:2], mon_act[1], mon_act[0],
                   mon_exp[13:10], mon_exp[9:2], mon_exp[1], mon_exp[0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    lit = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
            7'h7F, 7'h7B, 7'h01, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h00};
    m_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset_init");
    release_reset();

    // free run with the blank reset word
    idle(2 * FRAME - 1, 1'b0);

    // plain digits
    step(1'b1, 16'h1234, 4'h0, 1'b0);
    idle(2 * FRAME, 1'b0);

    // leading-zero blanking
    step(1'b1, 16'h0070, 4'h0, 1'b1);
    idle(2 * FRAME, 1'b1);

    // two loads in one frame: last wins, one ack
    step_to_phase(1, 1'b0);
    step(1'b1, 16'h1111, 4'h0, 1'b0);
    idle(5, 1'b0);
    step(1'b1, 16'h2222, 4'h0, 1'b0);
    idle(2 * FRAME, 1'b0);

    // load in the boundary cycle while an older load is pending
    step(1'b1, 16'h5678, 4'h3, 1'b0);
    step_to_phase(FRAME - 1, 1'b0);
    step(1'b1, 16'h9ABC, 4'h5, 1'b0);
    idle(2 * FRAME, 1'b0);

    // load right after a boundary stays pending a whole frame
    step(1'b1, 16'hDE0F, 4'h8, 1'b0);
    idle(2 * FRAME, 1'b0);

    // decimal points, then reset mid-slot with a load pending
    step(1'b1, 16'h8888, 4'b0100, 1'b0);
    idle(2 * FRAME, 1'b0);
    step(1'b1, 16'h4321, 4'hF, 1'b0);
    for (int i = 0; i < RD && (t % RD) != 2; i++) idle(1, 1'b0);
    @(negedge clk);
    checking = 1'b0;
    rst  = 1'b1;
    load = 1'b0;
    #1;
    check_reset("reset_mid");
    @(posedge clk);
    #1;
    check_reset("reset_hold");
    repeat (2) @(posedge clk);
    release_reset();
    idle(2 * FRAME, 1'b0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [15:0] v;
      if ($urandom_range(0, 31) == 0) blz_r = ~blz_r;
      if ($urandom_range(0, 2) == 0) v = 16'($urandom_range(0, 255));
      else v = 16'($urandom);
      step($urandom_range(0, 9) == 0, v, 4'($urandom), blz_r);
    end

    @(posedge clk);
    #2;
    checking = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
